// File: rtl/mips_alu_exec_unit_if.sv
// Operand/result bundle between the EX-stage pipeline and the ALU execute unit.
// The master drives an operation; the slave (the ALU) returns results, busy and HI/LO.
interface mips_alu_exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic [1:0]       alu_op;
    logic [5:0]       func;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             zero;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             md_done;

    modport master (
        output in_valid, alu_op, func, shamt, a, b,
        input  result, result_valid, zero, busy, hi, lo, md_done
    );

    modport slave (
        input  in_valid, alu_op, func, shamt, a, b,
        output result, result_valid, zero, busy, hi, lo, md_done
    );
endinterface

// File: rtl/mips_alu_exec_unit.sv
// MIPS EX-stage ALU control and execute unit: single-cycle ALU/shift ops with a
// registered result, plus iterative MULT/DIV into HI/LO that holds the pipeline via busy.
module mips_alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter bit MD_EN = 1'b1
) (
    input logic               clk,
    input logic               rst,
    mips_alu_exec_unit_if.slave io_bus
);
    localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010, F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100, F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110, F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010, F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;
    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    state_t             r_state, w_next;
    logic [SHW-1:0]     r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_mop;
    logic [WIDTH-1:0]   r_a_md;
    logic               r_is_div, r_neg_lo, r_neg_hi, r_div0;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_md_done;

    logic               r_sc_valid;
    logic [1:0]         r_op;
    logic [5:0]         r_func;
    logic [SHW-1:0]     r_shamt;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_result_valid, r_zero;

    logic               w_accept, w_is_md, w_md_start, w_sc_start;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_mul_upper, w_div_shift, w_div_trial;
    logic [2*WIDTH-1:0] w_p_step;
    logic [WIDTH-1:0]   w_hi_fix, w_lo_fix;
    logic [WIDTH-1:0]   w_alu;

    assign w_accept   = io_bus.in_valid && (r_state == S_IDLE);
    assign w_is_md    = MD_EN && (io_bus.alu_op == 2'b10) && (io_bus.func[5:2] == 4'b0110);
    assign w_md_start = w_accept && w_is_md;
    assign w_sc_start = w_accept && !w_is_md;

    // func[0] clear selects the signed variants (MULT/DIV); iteration runs on magnitudes
    assign w_a_neg = !io_bus.func[0] && io_bus.a[WIDTH-1];
    assign w_b_neg = !io_bus.func[0] && io_bus.b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -io_bus.a : io_bus.a;
    assign w_b_mag = w_b_neg ? -io_bus.b : io_bus.b;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_md_start) w_next = S_ITER;
            S_ITER:  if (r_cnt == LAST_ITER) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // r_p holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        w_mul_upper = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_mop} : '0);
        w_div_shift = r_p[2*WIDTH-1:WIDTH-1];
        w_div_trial = w_div_shift - {1'b0, r_mop};
        if (r_is_div) begin
            if (!w_div_trial[WIDTH]) w_p_step = {w_div_trial[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
            else                     w_p_step = {w_div_shift[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
        end else begin
            w_p_step = {w_mul_upper, r_p[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_hi_fix = r_p[2*WIDTH-1:WIDTH];
        w_lo_fix = r_p[WIDTH-1:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_hi_fix = r_a_md;
                w_lo_fix = '1;
            end else begin
                if (r_neg_lo) w_lo_fix = -r_p[WIDTH-1:0];
                if (r_neg_hi) w_hi_fix = -r_p[2*WIDTH-1:WIDTH];
            end
        end else if (r_neg_lo) begin
            {w_hi_fix, w_lo_fix} = -r_p;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_p       <= '0;
            r_mop     <= '0;
            r_a_md    <= '0;
            r_is_div  <= 1'b0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_md_done <= 1'b0;
        end else begin
            r_md_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_md_start) begin
                    r_cnt    <= '0;
                    r_p      <= {{WIDTH{1'b0}}, w_a_mag};
                    r_mop    <= w_b_mag;
                    r_a_md   <= io_bus.a;
                    r_is_div <= io_bus.func[1];
                    r_neg_lo <= w_a_neg ^ w_b_neg;
                    r_neg_hi <= w_a_neg;
                    r_div0   <= (io_bus.b == '0);
                end
                S_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_p   <= w_p_step;
                end
                S_FIX: begin
                    r_hi      <= w_hi_fix;
                    r_lo      <= w_lo_fix;
                    r_md_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_alu = '0;
        case (r_op)
            2'b00: w_alu = r_a + r_b;
            2'b01: w_alu = r_a - r_b;
            2'b10: begin
                case (r_func)
                    F_ADD, F_ADDU: w_alu = r_a + r_b;
                    F_SUB, F_SUBU: w_alu = r_a - r_b;
                    F_AND:  w_alu = r_a & r_b;
                    F_OR:   w_alu = r_a | r_b;
                    F_XOR:  w_alu = r_a ^ r_b;
                    F_NOR:  w_alu = ~(r_a | r_b);
                    F_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
                    F_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
                    F_SLL:  w_alu = r_b << r_shamt;
                    F_SRL:  w_alu = r_b >> r_shamt;
                    F_SRA:  w_alu = $signed(r_b) >>> r_shamt;
                    F_MFHI: if (MD_EN) w_alu = r_hi;
                    F_MFLO: if (MD_EN) w_alu = r_lo;
                    default: w_alu = '0;
                endcase
            end
            default: w_alu = '0;
        endcase
    end

    // Operands are captured on acceptance; the result register follows one edge later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sc_valid     <= 1'b0;
            r_op           <= '0;
            r_func         <= '0;
            r_shamt        <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_zero         <= 1'b0;
        end else begin
            r_sc_valid     <= w_sc_start;
            r_result_valid <= r_sc_valid;
            if (w_sc_start) begin
                r_op    <= io_bus.alu_op;
                r_func  <= io_bus.func;
                r_shamt <= io_bus.shamt;
                r_a     <= io_bus.a;
                r_b     <= io_bus.b;
            end
            if (r_sc_valid) begin
                r_result <= w_alu;
                r_zero   <= (w_alu == '0);
            end
        end
    end

    assign io_bus.result       = r_result;
    assign io_bus.result_valid = r_result_valid;
    assign io_bus.zero         = r_zero;
    assign io_bus.busy         = (r_state != S_IDLE);
    assign io_bus.hi           = r_hi;
    assign io_bus.lo           = r_lo;
    assign io_bus.md_done      = r_md_done;
endmodule

// File: doc/mips_alu_exec_unit.md
Name: mips_alu_exec_unit

Overview:
- Parametrised EX-stage ALU control plus execute unit for the MIPS pipeline.
- Decodes the main-control ALU op and the R-type func field, then executes single-cycle ALU/shift operations with a registered result.
- Runs multi-cycle iterative MULT/DIV into architectural HI/LO registers and raises busy so the hazard unit stalls the pipeline.

Parameters:
- WIDTH, 32, datapath width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width.
- MD_EN, 1, 1 = multiply/divide/MFHI/MFLO present; 0 = those funcs decode as unknown.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation presented this cycle.
- alu_op  in  2  00 = add (lw/sw), 01 = sub (beq), 10 = R-type use func, 11 = NOP.
- func  in  6  R-type function field.
- shamt  in  SHW  shift amount.
- a  in  WIDTH  operand rs.
- b  in  WIDTH  operand rt.
- result  out  WIDTH  registered ALU result.
- result_valid  out  1  one-cycle pulse, result valid.
- zero  out  1  registered (result == 0), qualified by result_valid.
- busy  out  1  mult/div in progress; upstream holds its inputs.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- md_done  out  1  one-cycle pulse, HI/LO just updated.

Behaviour:
- Reset (rst=1 at an edge): result=0, result_valid=0, zero=0, busy=0, hi=0, lo=0, md_done=0, FSM=IDLE. Reset mid-operation aborts it; HI/LO are not written.
- Accept rule: an operation is accepted only when in_valid=1 and busy=0. While busy=1, in_valid is ignored and upstream holds its inputs.
- Func codes: ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SLL 000000, SRL 000010, SRA 000011, MFHI 010000, MFLO 010010, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- Single-cycle ops (including alu_op 00/01/11, all non-MD funcs, MFHI, MFLO):
  - Accepted at edge T; result, zero and result_valid=1 appear after edge T+1.
  - result_valid is 0 in every cycle with no accepted single-cycle op.
- Arithmetic is modulo 2^WIDTH; ADD and ADDU behave identically, with no overflow trap.
- SLT compares signed, SLTU compares unsigned; result is 0 or 1 zero-extended.
- Shifts operate on b by shamt; SRA sign-fills.
- alu_op=11, or an unknown func (including MD funcs when MD_EN=0): result=0, zero=1, result_valid=1.
- MFHI/MFLO return the current hi/lo. An MFHI accepted in the cycle md_done=1 returns the new value.
- MD ops (MD_EN=1): accepted at edge T; no result_valid pulse.
- FSM IDLE -> ITER -> FIX -> IDLE:
  - ITER lasts WIDTH cycles: shift-add multiply, or restoring divide, one bit per cycle on magnitudes.
  - FIX lasts 1 cycle: sign correction, then HI/LO written on the FIX->IDLE edge.
- busy=1 for exactly WIDTH+1 cycles, from after edge T through the FIX cycle.
- md_done=1 in the first IDLE cycle, i.e. WIDTH+2 cycles after acceptance. A new op may be accepted in that same cycle.
- MULT/MULTU: {hi,lo} = full 2*WIDTH product, signed or unsigned respectively.
- DIV/DIVU: lo=quotient, hi=remainder. Signed division truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (both DIV and DIVU): hi=a, lo=all ones, same latency.
- Signed minimum / -1: lo=minimum, hi=0.

Test Plan:
- ADD a=7, b=0xFFFFFFFD -> one cycle later result=4, zero=0, result_valid pulse of 1 cycle.
- alu_op=01, a=b=0x55 -> result=0, zero=1. Then alu_op=11 -> result=0, result_valid=1.
- SRA b=0x80000000, shamt=4 -> 0xF8000000. SRL same inputs -> 0x08000000. SLTU a=1, b=0xFFFFFFFF -> 1. SLT same inputs -> 0.
- MULT a=-6, b=7:
  - busy high exactly 33 cycles; in_valid ADD presented during busy is ignored.
  - md_done then hi=0xFFFFFFFF, lo=0xFFFFFFD6; following MFLO -> 0xFFFFFFD6.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=9, b=0 -> hi=9, lo=0xFFFFFFFF. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- rst asserted 10 cycles into a DIV -> next cycle busy=0, hi=lo=0, md_done never pulses. Following ADD 1+1 -> result=2 one cycle after acceptance.
